// File: rtl/botsim_pkg.sv
// Shared constants and types for the banked BOTSIM register interface:
// kcpsm6 port addresses, per-bot register indices and map FSM states.
package botsim_pkg;

    localparam logic [7:0] PA_BANK    = 8'h00;
    localparam logic [7:0] PA_MOTCTL  = 8'h01;
    localparam logic [7:0] PA_LOCX    = 8'h02;
    localparam logic [7:0] PA_LOCY    = 8'h03;
    localparam logic [7:0] PA_BOTINFO = 8'h04;
    localparam logic [7:0] PA_SENSORS = 8'h05;
    localparam logic [7:0] PA_LMDIST  = 8'h06;
    localparam logic [7:0] PA_RMDIST  = 8'h07;
    localparam logic [7:0] PA_MAPX    = 8'h08;
    localparam logic [7:0] PA_MAPY    = 8'h09;
    localparam logic [7:0] PA_MAPVAL  = 8'h0A;
    localparam logic [7:0] PA_COMMIT  = 8'h0B;
    localparam logic [7:0] PA_STATUS  = 8'h0C;

    // Register index equals port address minus PA_LOCX.
    typedef enum logic [2:0] {
        REG_LOCX    = 3'd0,
        REG_LOCY    = 3'd1,
        REG_BOTINFO = 3'd2,
        REG_SENSORS = 3'd3,
        REG_LMDIST  = 3'd4,
        REG_RMDIST  = 3'd5
    } bot_reg_e;

    localparam int NUM_REGS = 6;

    typedef enum logic {
        MAP_IDLE = 1'b0,
        MAP_WAIT = 1'b1
    } map_state_e;

    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/botsim_map_lookup.sv
// World-map lookup engine: holds the map address, waits MAP_LAT cycles for
// the external map memory, then captures MapVal. busy is high while waiting.
module botsim_map_lookup
    import botsim_pkg::*;
#(
    parameter int MAP_LAT = 1,
    parameter int MAP_AW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_x,
    input  logic              wr_y,
    input  logic [7:0]        wr_data,
    input  logic [1:0]        map_val_i,
    output logic [MAP_AW-1:0] map_x,
    output logic [MAP_AW-1:0] map_y,
    output logic              busy,
    output logic [1:0]        val
);

    map_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [MAP_AW-1:0] x_q, x_d;
    logic [MAP_AW-1:0] y_q, y_d;
    logic [1:0]        val_q, val_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MAP_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        val_d   = val_q;
        // A new address always restarts the wait, abandoning any lookup in flight.
        if (wr_x || wr_y) begin
            if (wr_x) x_d = MAP_AW'(wr_data);
            if (wr_y) y_d = MAP_AW'(wr_data);
            cnt_d   = 3'(MAP_LAT);
            state_d = MAP_WAIT;
        end else if (state_q == MAP_WAIT) begin
            if (cnt_q == 3'd1) begin
                val_d   = map_val_i;
                cnt_d   = '0;
                state_d = MAP_IDLE;
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    assign map_x = x_q;
    assign map_y = y_q;
    assign busy  = (state_q == MAP_WAIT);
    assign val   = val_q;

endmodule

// File: rtl/botsim_regif.sv
// Banked kcpsm6 register window for NUM_BOTS rojobots: per-bot shadow
// registers with atomic commit, update handshake and a map lookup engine.
module botsim_regif
    import botsim_pkg::*;
#(
    parameter int NUM_BOTS = 4,
    parameter int MAP_LAT  = 1,
    parameter int MAP_AW   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Wr_Strobe,
    input  logic                  Rd_Strobe,
    input  logic [7:0]            AddrIn,
    input  logic [7:0]            DataIn,
    output logic [7:0]            DataOut,
    input  logic [8*NUM_BOTS-1:0] MotCtl,
    output logic [8*NUM_BOTS-1:0] LocX,
    output logic [8*NUM_BOTS-1:0] LocY,
    output logic [8*NUM_BOTS-1:0] Sensors,
    output logic [8*NUM_BOTS-1:0] BotInfo,
    output logic [8*NUM_BOTS-1:0] LMDist,
    output logic [8*NUM_BOTS-1:0] RMDist,
    output logic [NUM_BOTS-1:0]   upd_sysregs,
    input  logic [NUM_BOTS-1:0]   upd_ack,
    output logic [MAP_AW-1:0]     MapX,
    output logic [MAP_AW-1:0]     MapY,
    input  logic [1:0]            MapVal
);

    localparam int         BW  = bank_w(NUM_BOTS);
    localparam logic [8:0] NB9 = 9'(NUM_BOTS);

    logic [7:0]                               bank_q, bank_d;
    logic [NUM_BOTS-1:0][7:0]                 mot_q, mot_d;
    logic [NUM_BOTS-1:0][NUM_REGS-1:0][7:0]   sh_q, sh_d;
    logic [NUM_BOTS-1:0][NUM_REGS-1:0][7:0]   vis_q, vis_d;
    logic [NUM_BOTS-1:0]                      upd_q, upd_d;
    logic [NUM_BOTS-1:0]                      ovr_q, ovr_d;
    logic [7:0]                               dout_q, dout_d;

    logic          bank_ok;
    logic [BW-1:0] bidx;
    logic [2:0]    ridx;
    logic          is_shadow;
    logic          map_wr_x, map_wr_y, map_busy;
    logic [1:0]    map_val;

    assign bank_ok   = ({1'b0, bank_q} < NB9);
    assign bidx      = bank_q[BW-1:0];
    assign ridx      = 3'(AddrIn - PA_LOCX);
    assign is_shadow = (AddrIn >= PA_LOCX) && (AddrIn <= PA_RMDIST);
    assign map_wr_x  = Wr_Strobe && (AddrIn == PA_MAPX);
    assign map_wr_y  = Wr_Strobe && (AddrIn == PA_MAPY);

    botsim_map_lookup #(
        .MAP_LAT (MAP_LAT),
        .MAP_AW  (MAP_AW)
    ) u_map (
        .clk       (clk),
        .reset     (reset),
        .wr_x      (map_wr_x),
        .wr_y      (map_wr_y),
        .wr_data   (DataIn),
        .map_val_i (MapVal),
        .map_x     (MapX),
        .map_y     (MapY),
        .busy      (map_busy),
        .val       (map_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q <= '0;
            mot_q  <= '0;
            sh_q   <= '0;
            vis_q  <= '0;
            upd_q  <= '0;
            ovr_q  <= '0;
            dout_q <= '0;
        end else begin
            bank_q <= bank_d;
            mot_q  <= mot_d;
            sh_q   <= sh_d;
            vis_q  <= vis_d;
            upd_q  <= upd_d;
            ovr_q  <= ovr_d;
            dout_q <= dout_d;
        end
    end

    always_comb begin
        bank_d = bank_q;
        mot_d  = MotCtl;
        sh_d   = sh_q;
        vis_d  = vis_q;
        upd_d  = upd_q & ~upd_ack;
        ovr_d  = ovr_q;
        dout_d = 8'h00;

        // Clears come first so that a same-cycle commit set takes priority.
        if (Rd_Strobe && (AddrIn == PA_STATUS) && bank_ok) ovr_d[bidx] = 1'b0;

        if (Wr_Strobe) begin
            if (AddrIn == PA_BANK) bank_d = DataIn;
            if (is_shadow && bank_ok) sh_d[bidx][ridx] = DataIn;
            if ((AddrIn == PA_COMMIT) && bank_ok) begin
                vis_d[bidx] = sh_q[bidx];
                upd_d[bidx] = 1'b1;
                if (upd_q[bidx] && !upd_ack[bidx]) ovr_d[bidx] = 1'b1;
            end
        end

        case (AddrIn)
            PA_BANK:   dout_d = bank_q;
            PA_MOTCTL: if (bank_ok) dout_d = mot_q[bidx];
            PA_LOCX, PA_LOCY, PA_BOTINFO, PA_SENSORS, PA_LMDIST, PA_RMDIST:
                       if (bank_ok) dout_d = sh_q[bidx][ridx];
            PA_MAPX:   dout_d = 8'(MapX);
            PA_MAPY:   dout_d = 8'(MapY);
            PA_MAPVAL: dout_d = {map_busy, 5'b0, map_val};
            PA_STATUS: if (bank_ok) dout_d = {6'b0, ovr_q[bidx], upd_q[bidx]};
            default:   dout_d = 8'h00;
        endcase
    end

    for (genvar b = 0; b < NUM_BOTS; b++) begin : g_out
        assign LocX[8*b +: 8]    = vis_q[b][REG_LOCX];
        assign LocY[8*b +: 8]    = vis_q[b][REG_LOCY];
        assign BotInfo[8*b +: 8] = vis_q[b][REG_BOTINFO];
        assign Sensors[8*b +: 8] = vis_q[b][REG_SENSORS];
        assign LMDist[8*b +: 8]  = vis_q[b][REG_LMDIST];
        assign RMDist[8*b +: 8]  = vis_q[b][REG_RMDIST];
    end

    assign upd_sysregs = upd_q;
    assign DataOut     = dout_q;

endmodule

// File: tb/tb_botsim_regif.sv
// Directed bench for botsim_regif with four bots and a three-cycle map latency.
module tb_botsim_regif;

    localparam int NB = 4;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Wr_Strobe = 1'b0;
    logic          Rd_Strobe = 1'b0;
    logic [7:0]    AddrIn = 8'h00;
    logic [7:0]    DataIn = 8'h00;
    logic [7:0]    DataOut;
    logic [8*NB-1:0] MotCtl = '0;
    logic [8*NB-1:0] LocX, LocY, Sensors, BotInfo, LMDist, RMDist;
    logic [NB-1:0] upd_sysregs;
    logic [NB-1:0] upd_ack = '0;
    logic [7:0]    MapX, MapY;
    logic [1:0]    MapVal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // World map model: only cell (5,7) holds value 2, every other cell holds 1.
    assign MapVal = (MapX == 8'h05 && MapY == 8'h07) ? 2'b10 : 2'b01;

    botsim_regif #(.NUM_BOTS(NB), .MAP_LAT(ML), .MAP_AW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .Wr_Strobe   (Wr_Strobe),
        .Rd_Strobe   (Rd_Strobe),
        .AddrIn      (AddrIn),
        .DataIn      (DataIn),
        .DataOut     (DataOut),
        .MotCtl      (MotCtl),
        .LocX        (LocX),
        .LocY        (LocY),
        .Sensors     (Sensors),
        .BotInfo     (BotInfo),
        .LMDist      (LMDist),
        .RMDist      (RMDist),
        .upd_sysregs (upd_sysregs),
        .upd_ack     (upd_ack),
        .MapX        (MapX),
        .MapY        (MapY),
        .MapVal      (MapVal)
    );

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        AddrIn = a;
        DataIn = d;
        Wr_Strobe = 1'b1;
        @(negedge clk);
        Wr_Strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        AddrIn = a;
        Rd_Strobe = 1'b1;
        @(negedge clk);
        Rd_Strobe = 1'b0;
        d = DataOut;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        checks++;
        if (DataOut !== 8'h00 || LocX !== '0 || upd_sysregs !== '0 || MapX !== 8'h00) begin
            errors++;
            $display("FAIL reset_init: DataOut=%h LocX=%h upd=%b MapX=%h, expected all 0", DataOut, LocX, upd_sysregs, MapX);
        end
        wr(8'h00, 8'h00);
        wr(8'h02, 8'h5A);
        wr(8'h0B, 8'h00);
        checks++;
        if (LocX[7:0] !== 8'h5A || upd_sysregs !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset_commit: LocX0=%h upd=%b, expected 5a 0001", LocX[7:0], upd_sysregs);
        end
        wr(8'h08, 8'h05);
        wr(8'h09, 8'h07);
        repeat (5) @(negedge clk);
        rd(8'h0A, d);
        checks++;
        if (d !== 8'h02) begin
            errors++;
            $display("FAIL pre_reset_map: got %h expected 02", d);
        end
        wr(8'h08, 8'h09);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (DataOut !== 8'h00 || LocX !== '0 || upd_sysregs !== '0 || MapX !== 8'h00 || MapY !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: DataOut=%h LocX=%h upd=%b MapX=%h MapY=%h, expected all 0", DataOut, LocX, upd_sysregs, MapX, MapY);
        end
        @(negedge clk);
        reset = 1'b0;
        rd(8'h0A, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_mapval: got %h expected 00", d);
        end
    endtask

    task automatic test_commit;
        logic [7:0] d;
        wr(8'h00, 8'h02);
        wr(8'h02, 8'h11);
        wr(8'h03, 8'h22);
        checks++;
        if (LocX[23:16] !== 8'h00 || upd_sysregs !== 4'b0000) begin
            errors++;
            $display("FAIL shadow_hidden: LocX2=%h upd=%b, expected 00 0000", LocX[23:16], upd_sysregs);
        end
        rd(8'h02, d);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("FAIL shadow_readback: got %h expected 11", d);
        end
        wr(8'h0B, 8'h00);
        checks++;
        if (LocX !== 32'h0011_0000 || LocY !== 32'h0022_0000 || upd_sysregs !== 4'b0100) begin
            errors++;
            $display("FAIL atomic_commit: LocX=%h LocY=%h upd=%b, expected 00110000 00220000 0100", LocX, LocY, upd_sysregs);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        wr(8'h0B, 8'h00);
        rd(8'h0C, d);
        checks++;
        if (d !== 8'h03) begin
            errors++;
            $display("FAIL status_overrun: got %h expected 03", d);
        end
        rd(8'h0C, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL status_cleared: got %h expected 01", d);
        end
        @(negedge clk);
        AddrIn = 8'h0B;
        Wr_Strobe = 1'b1;
        upd_ack = 4'b0100;
        @(negedge clk);
        Wr_Strobe = 1'b0;
        upd_ack = 4'b0000;
        checks++;
        if (upd_sysregs !== 4'b0100) begin
            errors++;
            $display("FAIL collision_upd: got %b expected 0100", upd_sysregs);
        end
        rd(8'h0C, d);
        checks++;
        if (d !== 8'h01) begin
            errors++;
            $display("FAIL collision_status: got %h expected 01", d);
        end
        @(negedge clk);
        upd_ack = 4'b0100;
        @(negedge clk);
        upd_ack = 4'b0000;
        checks++;
        if (upd_sysregs !== 4'b0000) begin
            errors++;
            $display("FAIL ack_clear: got %b expected 0000", upd_sysregs);
        end
    endtask

    task automatic test_map_latency;
        wr(8'h08, 8'h05);
        wr(8'h09, 8'h07);
        AddrIn = 8'h0A;
        for (int k = 1; k <= ML; k++) begin
            @(negedge clk);
            checks++;
            if (DataOut !== 8'h80) begin
                errors++;
                $display("FAIL map_busy_%0d: got %h expected 80", k, DataOut);
            end
        end
        @(negedge clk);
        checks++;
        if (DataOut !== 8'h02 || MapX !== 8'h05 || MapY !== 8'h07) begin
            errors++;
            $display("FAIL map_result: DataOut=%h MapX=%h MapY=%h, expected 02 05 07", DataOut, MapX, MapY);
        end
    endtask

    task automatic test_map_restart;
        wr(8'h09, 8'h03);
        wr(8'h09, 8'h07);
        AddrIn = 8'h0A;
        for (int k = 1; k <= ML; k++) begin
            @(negedge clk);
            checks++;
            if (DataOut !== 8'h82) begin
                errors++;
                $display("FAIL restart_busy_%0d: got %h expected 82", k, DataOut);
            end
        end
        @(negedge clk);
        checks++;
        if (DataOut !== 8'h02) begin
            errors++;
            $display("FAIL restart_result: got %h expected 02", DataOut);
        end
    endtask

    task automatic test_bank_range;
        logic [7:0] d;
        wr(8'h00, 8'h07);
        wr(8'h02, 8'h99);
        wr(8'h0B, 8'h00);
        checks++;
        if (LocX !== 32'h0011_0000 || LocY !== 32'h0022_0000 || upd_sysregs !== 4'b0000) begin
            errors++;
            $display("FAIL oor_outputs: LocX=%h LocY=%h upd=%b, expected 00110000 00220000 0000", LocX, LocY, upd_sysregs);
        end
        rd(8'h02, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL oor_read: got %h expected 00", d);
        end
        rd(8'h00, d);
        checks++;
        if (d !== 8'h07) begin
            errors++;
            $display("FAIL oor_bank: got %h expected 07", d);
        end
        rd(8'h0C, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL oor_status: got %h expected 00", d);
        end
        rd(8'h3F, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL unmapped_read: got %h expected 00", d);
        end
    endtask

    task automatic test_motctl;
        logic [7:0] d;
        MotCtl = 32'h3C00_A500;
        wr(8'h00, 8'h01);
        rd(8'h01, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL motctl_bank1: got %h expected a5", d);
        end
        wr(8'h00, 8'h03);
        rd(8'h01, d);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL motctl_bank3: got %h expected 3c", d);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_commit();
        test_overrun();
        test_map_latency();
        test_map_restart();
        test_bank_range();
        test_motctl();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
